// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared types and helpers for the parameterised synchronous FIFO.
//   fifo_status_t  : packed bundle of the FIFO status/error flags
//   fifo_addr_w()  : address width for a given depth
//   fifo_cnt_w()   : pointer/count width (address + wrap bit)
//   fifo_is_pow2() : depth legality check used at elaboration
// -----------------------------------------------------------------------------
package fifo_pkg;

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
      logic overflow;
      logic underflow;
   } fifo_status_t;

   function automatic int fifo_addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // One extra bit distinguishes full from empty when the addresses match.
   function automatic int fifo_cnt_w(input int depth);
      return fifo_addr_w(depth) + 1;
   endfunction

   function automatic bit fifo_is_pow2(input int depth);
      return (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// -----------------------------------------------------------------------------
// fifo_mem_2p
// WIDTH x DEPTH storage array, no reset.
//   clk      in  : write clock
//   wr_en    in  : write strobe (already qualified by the FIFO)
//   wr_addr  in  : write address
//   wr_data  in  : write word
//   rd_addr  in  : read address
//   rd_data  out : word at rd_addr (asynchronous read)
// -----------------------------------------------------------------------------
module fifo_mem_2p
   import fifo_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          wr_en,
   input  logic [fifo_addr_w(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]              wr_data,
   input  logic [fifo_addr_w(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]              rd_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/param_sync_fifo.sv
// -----------------------------------------------------------------------------
// param_sync_fifo
// Single-clock FIFO with optional first-word-fall-through output.
//   clk          in  : clock, rising edge
//   rst          in  : asynchronous active-high reset (deassertion synchronised
//                      externally)
//   wr_en        in  : write request, accepted when not full
//   wr_data      in  : write word
//   rd_en        in  : read request (FWFT=1: acknowledge of the head word)
//   clr_err      in  : clears sticky overflow/underflow
//   rd_data      out : read word
//   rd_valid     out : rd_data holds a valid word
//   full/empty   out : occupancy == DEPTH / == 0
//   almost_full  out : count >= AF_LEVEL
//   almost_empty out : count <= AE_LEVEL
//   count        out : occupancy 0..DEPTH
//   overflow     out : sticky, write attempted while full
//   underflow    out : sticky, read attempted while empty
// -----------------------------------------------------------------------------
module param_sync_fifo
   import fifo_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2,
   parameter int FWFT     = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_en,
   input  logic [WIDTH-1:0]             wr_data,
   input  logic                         rd_en,
   input  logic                         clr_err,
   output logic [WIDTH-1:0]             rd_data,
   output logic                         rd_valid,
   output logic                         full,
   output logic                         empty,
   output logic                         almost_full,
   output logic                         almost_empty,
   output logic [fifo_cnt_w(DEPTH)-1:0] count,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int ADDR_W = fifo_addr_w(DEPTH);
   localparam int CNT_W  = fifo_cnt_w(DEPTH);

   // Reject illegal configurations at elaboration time.
   generate
      if (!fifo_is_pow2(DEPTH)) begin : g_bad_depth
         $error("param_sync_fifo: DEPTH must be a power of two >= 2");
      end
      if (AF_LEVEL < 0 || AF_LEVEL > DEPTH) begin : g_bad_af
         $error("param_sync_fifo: AF_LEVEL must lie in 0..DEPTH");
      end
      if (AE_LEVEL < 0 || AE_LEVEL > DEPTH) begin : g_bad_ae
         $error("param_sync_fifo: AE_LEVEL must lie in 0..DEPTH");
      end
   endgenerate

   localparam logic [CNT_W-1:0] AF_CNT = CNT_W'(AF_LEVEL);
   localparam logic [CNT_W-1:0] AE_CNT = CNT_W'(AE_LEVEL);

   logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic [CNT_W-1:0] count_w;
   logic             wr_acc, rd_acc;
   logic [WIDTH-1:0] head_word;
   fifo_status_t     status;

   // Flags and count derive purely from the registered pointers, so they
   // always describe the state after the most recent edge.
   always_comb begin
      count_w             = wr_ptr_q - rd_ptr_q;
      status.full         = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                            (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
      status.empty        = (wr_ptr_q == rd_ptr_q);
      status.almost_full  = (count_w >= AF_CNT);
      status.almost_empty = (count_w <= AE_CNT);
      status.overflow     = overflow_q;
      status.underflow    = underflow_q;
   end

   // Acceptance uses only pre-edge full/empty: a read on a full FIFO does not
   // make room for a same-cycle write, and vice versa.
   assign wr_acc = wr_en && !status.full;
   assign rd_acc = rd_en && !status.empty;

   always_comb begin
      wr_ptr_d    = wr_ptr_q + {{(CNT_W-1){1'b0}}, wr_acc};
      rd_ptr_d    = rd_ptr_q + {{(CNT_W-1){1'b0}}, rd_acc};
      // A new error event takes priority over a same-cycle clear.
      overflow_d  = (wr_en && status.full)  || (overflow_q  && !clr_err);
      underflow_d = (rd_en && status.empty) || (underflow_q && !clr_err);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   fifo_mem_2p #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr_q[ADDR_W-1:0]),
      .wr_data (wr_data),
      .rd_addr (rd_ptr_q[ADDR_W-1:0]),
      .rd_data (head_word)
   );

   generate
      if (FWFT != 0) begin : g_fwft
         // Head word is presented directly; masked to zero while empty so the
         // output is deterministic after reset.
         assign rd_data  = status.empty ? '0 : head_word;
         assign rd_valid = !status.empty;
      end else begin : g_std
         logic [WIDTH-1:0] rd_data_q, rd_data_d;
         logic             rd_valid_q, rd_valid_d;

         always_comb begin
            rd_data_d  = rd_data_q;
            rd_valid_d = rd_acc;
            if (rd_acc) begin
               rd_data_d = head_word;
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rd_data_q  <= '0;
               rd_valid_q <= 1'b0;
            end else begin
               rd_data_q  <= rd_data_d;
               rd_valid_q <= rd_valid_d;
            end
         end

         assign rd_data  = rd_data_q;
         assign rd_valid = rd_valid_q;
      end
   endgenerate

   assign full         = status.full;
   assign empty        = status.empty;
   assign almost_full  = status.almost_full;
   assign almost_empty = status.almost_empty;
   assign overflow     = status.overflow;
   assign underflow    = status.underflow;
   assign count        = count_w;

endmodule
